alu_result_display: RTL and testbench
=====================================

ALU_RESULT_DISPLAY -- requirements
Module: alu_result_display

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clock cycles each digit stays selected during scanning (minimum 2).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 done_in  input  1  one-cycle pulse from the ALU; result inputs are valid in the same cycle.
REQ-005 y_in  input  8  unsigned ALU result (0..255).
REQ-006 ovf_in  input  1  ALU overflow flag, valid with done_in.
REQ-007 zero_in  input  1  ALU zero flag, valid with done_in.
REQ-008 seg  output  7  segment drive, active-low; seg[0]=a through seg[6]=g.
REQ-009 dp  output  1  decimal point drive, active-low.
REQ-010 an  output  4  digit select, active-low one-hot; an[0]=units, an[1]=tens, an[2]=hundreds, an[3]=status.
REQ-011 conv_busy  output  1  high while a conversion or a display write is in progress.
REQ-012 upd  output  1  one-cycle pulse on the edge the display registers take a new value.

Function
REQ-013 FSM states SHALL be IDLE, CONV and WRITE, with IDLE as the reset state.
REQ-014 In IDLE, an edge with done_in=1 SHALL capture y_in into an 8-bit shift register, capture ovf_in/zero_in, clear the 12-bit BCD accumulator and the bit counter, and enter CONV.
REQ-015 Each CONV edge SHALL do one double-dabble step: add 3 to every BCD nibble ≥5, then shift {bcd, shreg} left by 1; the counter increments.
REQ-016 After the 8th CONV edge the FSM SHALL enter WRITE; the WRITE edge copies the BCD digits and flags into the display registers, pulses upd, and returns to IDLE.
REQ-017 Latency SHALL be fixed: upd is high in the cycle 10 edges after the edge that sampled done_in.
REQ-018 conv_busy SHALL be 1 in CONV and WRITE and 0 in IDLE.
REQ-019 A done_in during CONV or WRITE SHALL store y_in/ovf_in/zero_in in a one-entry pending buffer and set a pending flag; a later one overwrites the buffer (newest wins).
REQ-020 On the WRITE edge, if pending=1, the FSM SHALL load from the pending buffer, clear pending, and enter CONV directly instead of IDLE.
REQ-021 A done_in on the WRITE edge itself SHALL set pending (same rule as REQ-019).
REQ-022 Leading-zero blanking: hundreds blank if 0; tens blank if hundreds and tens are both 0; units always shown.
REQ-023 The status digit SHALL show 'E' (seg=7'b0000110) when the latched overflow is 1, otherwise blank (7'b1111111).
REQ-024 dp SHALL be 0 (lit) only while the units digit is selected and the latched zero flag is 1; otherwise 1.
REQ-025 Digit encodings SHALL be standard, active-low; '0'=7'b1000000, '7'=7'b1111000, '2'=7'b0100100, '5'=7'b0010010.
REQ-026 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap the digit index advances 0→1→2→3→0.
REQ-027 seg, an and dp SHALL be registered outputs that follow the current digit index and display registers, one cycle behind.
REQ-028 Scanning SHALL run continuously and independently of the FSM; display registers change only on WRITE.

Reset
REQ-029 While rst=1, on every edge: FSM=IDLE, pending=0, counters=0, digit index=0, display registers show units=0, other digits blank, overflow=0, zero=0.
REQ-030 After reset: conv_busy=0, upd=0, an=4'b1110, seg=7'b1000000, dp=1.
REQ-031 rst during CONV or WRITE SHALL abandon the conversion without any upd pulse, and SHALL drop any pending result.

Verification
REQ-032 done_in with y_in=255, ovf=0, zero=0 -> upd 10 edges later; units/tens/hundreds show 5,5,2; status blank; dp=1.
REQ-033 y_in=7, ovf=1 -> hundreds and tens blank, units '7', status 'E'; y_in=0 with zero=1 -> units '0', dp lit on an=4'b1110 only.
REQ-034 REFRESH_DIV=4 -> an sequence 1110,1101,1011,0111,1110, each held exactly 4 cycles.
REQ-035 done_in y=100 followed 3 cycles later by done_in y=42 and then y=9 -> first upd shows 100; conversion restarts immediately; second upd shows 9 (42 dropped); conv_busy stays high throughout.
REQ-036 rst asserted 4 edges into a conversion of y=200 -> no upd pulse; display returns to reset value; a later done_in y=13 converts normally.

Source files
------------

// File: rtl/alu_result_display.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_display
//  Purpose  : Converts an 8-bit ALU result to BCD (double dabble, one bit per
//             clock) and shows it on a 4-digit multiplexed 7-segment display.
//             The display shows units, tens and hundreds with leading-zero
//             blanking, plus a status digit ('E' on overflow). The decimal
//             point on the units digit shows the zero flag. A one-entry
//             pending buffer holds a result that arrives during a conversion.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             done_in           - result-valid pulse from the ALU
//             y_in, ovf_in,
//             zero_in           - ALU result and flags, valid with done_in
//             seg, dp, an       - active-low segment / dp / digit drives
//             conv_busy         - conversion or display write in progress
//             upd               - pulse when the display registers update
//  Revision : 1.0 - initial release
// ============================================================================
module alu_result_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       done_in,
  input  logic [7:0] y_in,
  input  logic       ovf_in,
  input  logic       zero_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       conv_busy,
  output logic       upd
);

  localparam int         CNT_W     = $clog2(REFRESH_DIV);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, WRITE = 2'd2} state_t;

  state_t      state_q;
  logic [7:0]  shreg_q;
  logic [11:0] bcd_q;
  logic [2:0]  bitcnt_q;
  logic        ovf_cap_q, zero_cap_q;

  logic        pend_q;
  logic [7:0]  pend_y_q;
  logic        pend_ovf_q, pend_zero_q;

  logic [11:0] disp_bcd_q;
  logic        disp_ovf_q, disp_zero_q;
  logic        upd_q;

  logic [19:0] step_d;

  // One double-dabble iteration: correct every nibble >= 5, then shift.
  function automatic logic [19:0] dabble(input logic [11:0] b, input logic [7:0] s);
    logic [11:0] a;
    for (int n = 0; n < 3; n++) begin
      a[n*4 +: 4] = (b[n*4 +: 4] >= 4'd5) ? b[n*4 +: 4] + 4'd3 : b[n*4 +: 4];
    end
    return {a[10:0], s, 1'b0};
  endfunction

  always_comb begin
    step_d = dabble(bcd_q, shreg_q);
  end

  // --------------------------------------------------------------------------
  // Conversion FSM. A pending result is consumed in preference to a new
  // done_in; a done_in arriving on the same edge refills the buffer.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= 8'd0;
      bcd_q       <= 12'd0;
      bitcnt_q    <= 3'd0;
      ovf_cap_q   <= 1'b0;
      zero_cap_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_y_q    <= 8'd0;
      pend_ovf_q  <= 1'b0;
      pend_zero_q <= 1'b0;
      disp_bcd_q  <= 12'd0;
      disp_ovf_q  <= 1'b0;
      disp_zero_q <= 1'b0;
      upd_q       <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pend_q) begin
            shreg_q    <= pend_y_q;
            ovf_cap_q  <= pend_ovf_q;
            zero_cap_q <= pend_zero_q;
            bcd_q      <= 12'd0;
            bitcnt_q   <= 3'd0;
            pend_q     <= 1'b0;
            state_q    <= CONV;
            if (done_in) begin
              pend_q      <= 1'b1;
              pend_y_q    <= y_in;
              pend_ovf_q  <= ovf_in;
              pend_zero_q <= zero_in;
            end
          end else if (done_in) begin
            shreg_q    <= y_in;
            ovf_cap_q  <= ovf_in;
            zero_cap_q <= zero_in;
            bcd_q      <= 12'd0;
            bitcnt_q   <= 3'd0;
            state_q    <= CONV;
          end
        end
        CONV: begin
          {bcd_q, shreg_q} <= step_d;
          bitcnt_q         <= bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_q <= WRITE;
          end
          if (done_in) begin
            pend_q      <= 1'b1;
            pend_y_q    <= y_in;
            pend_ovf_q  <= ovf_in;
            pend_zero_q <= zero_in;
          end
        end
        WRITE: begin
          disp_bcd_q  <= bcd_q;
          disp_ovf_q  <= ovf_cap_q;
          disp_zero_q <= zero_cap_q;
          upd_q       <= 1'b1;
          if (pend_q) begin
            shreg_q    <= pend_y_q;
            ovf_cap_q  <= pend_ovf_q;
            zero_cap_q <= pend_zero_q;
            bcd_q      <= 12'd0;
            bitcnt_q   <= 3'd0;
            pend_q     <= 1'b0;
            state_q    <= CONV;
          end else begin
            state_q <= IDLE;
          end
          // Later assignment wins: a result arriving now refills the buffer.
          if (done_in) begin
            pend_q      <= 1'b1;
            pend_y_q    <= y_in;
            pend_ovf_q  <= ovf_in;
            pend_zero_q <= zero_in;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Display scanning, free-running and independent of the FSM.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] refcnt_q, refcnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             dp_q, dp_d;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    refcnt_d = refcnt_q + CNT_W'(1);
    idx_d    = idx_q;
    if (refcnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      refcnt_d = '0;
      idx_d    = idx_q + 2'd1;
    end

    an_d = ~(4'b0001 << idx_q);
    dp_d = ~((idx_q == 2'd0) && disp_zero_q);
    case (idx_q)
      2'd0:    seg_d = glyph(disp_bcd_q[3:0]);
      2'd1:    seg_d = (disp_bcd_q[11:4] == 8'd0) ? SEG_BLANK : glyph(disp_bcd_q[7:4]);
      2'd2:    seg_d = (disp_bcd_q[11:8] == 4'd0) ? SEG_BLANK : glyph(disp_bcd_q[11:8]);
      default: seg_d = disp_ovf_q ? SEG_E : SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refcnt_q <= '0;
      idx_q    <= 2'd0;
      seg_q    <= SEG_ZERO;
      an_q     <= 4'b1110;
      dp_q     <= 1'b1;
    end else begin
      refcnt_q <= refcnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      dp_q     <= dp_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign dp        = dp_q;
  assign upd       = upd_q;
  assign conv_busy = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_result_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_result_display
//  Purpose  : Self-checking bench for alu_result_display (REFRESH_DIV = 4).
//             Expected display content is computed from the decimal value of
//             the result with division/modulo and a glyph table.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       done_in = 1'b0;
  logic [7:0] y_in = 8'd0;
  logic       ovf_in = 1'b0;
  logic       zero_in = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       conv_busy;
  logic       upd;

  int errors = 0;
  int checks = 0;

  alu_result_display #(.REFRESH_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .done_in   (done_in),
    .y_in      (y_in),
    .ovf_in    (ovf_in),
    .zero_in   (zero_in),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .conv_busy (conv_busy),
    .upd       (upd)
  );

  always #5 clk = ~clk;

  // Standard active-low 7-segment glyphs, seg[0]=a .. seg[6]=g.
  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected segments for display position pos (0 units .. 3 status).
  function automatic logic [6:0] model_seg(input int pos, input int y, input bit ovf);
    case (pos)
      0: return glyph(y % 10);
      1: return (y < 10)  ? 7'b1111111 : glyph((y / 10) % 10);
      2: return (y < 100) ? 7'b1111111 : glyph(y / 100);
      default: return ovf ? 7'b0000110 : 7'b1111111;
    endcase
  endfunction

  // Tasks start and end #1 after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_scan(input int y, input bit ovf, input bit zero, input int n,
                            input string name);
    int pos;
    for (int i = 0; i < n; i++) begin
      tick();
      case (an)
        4'b1110: pos = 0;
        4'b1101: pos = 1;
        4'b1011: pos = 2;
        4'b0111: pos = 3;
        default: pos = -1;
      endcase
      checks++;
      if (pos < 0) begin
        errors++;
        $display("FAIL %s an: got %b, required one-hot-low", name, an);
      end else begin
        if (seg !== model_seg(pos, y, ovf)) begin
          errors++;
          $display("FAIL %s seg[pos %0d]: got %b, required %b", name, pos, seg,
                   model_seg(pos, y, ovf));
        end
        checks++;
        if (dp !== ((pos == 0 && zero) ? 1'b0 : 1'b1)) begin
          errors++;
          $display("FAIL %s dp[pos %0d]: got %b, required %b", name, pos, dp,
                   (pos == 0 && zero) ? 1'b0 : 1'b1);
        end
      end
    end
  endtask

  // Counts edges until upd is seen (bounded); 0 means it never came.
  task automatic wait_upd(input int limit, output int k);
    k = 0;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (upd === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  // Sends one result and checks busy, latency and the resulting display.
  task automatic run_one(input int y, input bit ovf, input bit zero, input string name);
    int first;
    first = 0;
    done_in = 1'b1; y_in = 8'(y); ovf_in = ovf; zero_in = zero;
    tick();                               // sampling edge
    done_in = 1'b0;
    checks++;
    if (conv_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_start: got %b, required 1", name, conv_busy);
    end
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (upd === 1'b1) begin
        first = k;
        break;
      end
      if (conv_busy !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL %s busy_during: got %b, required 1 at edge %0d", name, conv_busy, k);
      end
    end
    // Sampling edge closes cycle 0; the pulse is in cycle 10.
    checks++;
    if (first != 9) begin
      errors++;
      $display("FAIL %s latency: got upd after edge %0d, required edge 9", name, first);
    end
    checks++;
    if (conv_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_end: got %b, required 0", name, conv_busy);
    end
    check_scan(y, ovf, zero, 20, name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (conv_busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b, required 0", conv_busy); end
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL reset upd: got %b, required 0", upd); end
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL reset an: got %b, required 1110", an); end
    checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL reset seg: got %b, required 1000000", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset dp: got %b, required 1", dp); end
    rst = 1'b0;
  endtask

  task automatic test_refresh();
    logic [3:0] prev;
    int run, trans;
    bit seen;
    prev = an; run = 0; trans = 0; seen = 0;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (an !== prev) begin
        if (seen) begin
          trans++;
          checks++;
          if (run != 4) begin
            errors++;
            $display("FAIL refresh hold: an=%b held %0d cycles, required 4", prev, run);
          end
          checks++;
          if (an !== {prev[2:0], prev[3]}) begin
            errors++;
            $display("FAIL refresh order: got %b after %b, required %b", an, prev,
                     {prev[2:0], prev[3]});
          end
        end
        seen = 1; run = 1; prev = an;
      end else begin
        run++;
      end
    end
    checks++;
    if (trans < 8) begin
      errors++;
      $display("FAIL refresh transitions: got %0d, required at least 8", trans);
    end
  endtask

  task automatic test_directed();
    run_one(255, 1'b0, 1'b0, "y255");
    run_one(7,   1'b1, 1'b0, "y7_ovf");
    run_one(0,   1'b0, 1'b1, "y0_zero");
    run_one(100, 1'b0, 1'b0, "y100");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_one(int'($urandom_range(255)), 1'($urandom_range(1)), 1'($urandom_range(1)), "random");
    end
  endtask

  // 100, then 42 and 9 during the conversion: 42 is overwritten by 9.
  task automatic test_back_to_back();
    int first, second;
    bit busy_ok;
    busy_ok = 1;
    first = 0;
    second = 0;
    done_in = 1'b1; y_in = 8'd100; ovf_in = 1'b0; zero_in = 1'b0;
    tick();                               // E0
    done_in = 1'b0;
    tick(); tick();                       // E1, E2
    done_in = 1'b1; y_in = 8'd42;
    tick();                               // E3
    y_in = 8'd9;
    tick();                               // E4
    done_in = 1'b0;
    for (int k = 5; k <= 14; k++) begin
      tick();
      if (upd === 1'b1) begin first = k; break; end
      if (conv_busy !== 1'b1) busy_ok = 0;
    end
    checks++;
    if (first != 9) begin
      errors++;
      $display("FAIL b2b first_latency: got edge %0d, required 9", first);
    end
    checks++;
    if (conv_busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b busy_at_write: got %b, required 1", conv_busy);
    end
    check_scan(100, 1'b0, 1'b0, 8, "b2b_first");   // edges 10..17
    for (int k = 18; k <= 30; k++) begin
      tick();
      if (upd === 1'b1) begin second = k; break; end
    end
    checks++;
    if (second != 18) begin
      errors++;
      $display("FAIL b2b second_latency: got edge %0d, required 18", second);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL b2b busy_gap: got 0 during conversions, required 1");
    end
    check_scan(9, 1'b0, 1'b0, 20, "b2b_second");
  endtask

  // A result arriving exactly on the write edge must still be displayed.
  task automatic test_done_on_write();
    int k;
    done_in = 1'b1; y_in = 8'd64; ovf_in = 1'b0; zero_in = 1'b0;
    tick();                               // E0
    done_in = 1'b0;
    repeat (8) tick();                    // E1..E8
    done_in = 1'b1; y_in = 8'd31; ovf_in = 1'b1; zero_in = 1'b1;
    tick();                               // E9 (write edge)
    done_in = 1'b0;
    checks++;
    if (upd !== 1'b1) begin
      errors++;
      $display("FAIL write_edge upd: got %b, required 1", upd);
    end
    check_scan(64, 1'b0, 1'b0, 8, "write_edge_first");
    wait_upd(20, k);
    checks++;
    if (k == 0) begin
      errors++;
      $display("FAIL write_edge second_upd: got none, required a pulse");
    end
    check_scan(31, 1'b1, 1'b1, 20, "write_edge_second");
  endtask

  // Reset mid-conversion with a pending result queued.
  task automatic test_reset_mid();
    int k;
    bit saw_upd;
    saw_upd = 0;
    done_in = 1'b1; y_in = 8'd200; ovf_in = 1'b1; zero_in = 1'b0;
    tick();                               // E0
    done_in = 1'b0;
    tick();                               // E1
    done_in = 1'b1; y_in = 8'd77;
    tick();                               // E2 -> pending
    done_in = 1'b0;
    tick();                               // E3
    rst = 1'b1;
    tick(); tick();                       // E4, E5 in reset
    rst = 1'b0;
    checks++;
    if (conv_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid busy: got %b, required 0", conv_busy);
    end
    for (int i = 0; i < 24; i++) begin
      tick();
      if (upd === 1'b1) saw_upd = 1;
    end
    checks++;
    if (saw_upd) begin
      errors++;
      $display("FAIL rst_mid upd: got pulse, required none");
    end
    check_scan(0, 1'b0, 1'b0, 20, "rst_mid_display");
    run_one(13, 1'b0, 1'b0, "after_rst_y13");
    wait_upd(1, k);
  endtask

  initial begin
    test_reset();
    test_refresh();
    test_directed();
    test_random();
    test_back_to_back();
    test_done_on_write();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
